// File: rtl/stopwatch.sv
// stopwatch: up-counting elapsed-time block with prescaled tick input,
// pause/resume, clear, and a lap-capture register with a one-cycle valid pulse.
// Optional feature: define STOPWATCH_SATURATE_EN to make `elapsed` saturate at
// all-ones with a sticky `overflow`; otherwise `elapsed` wraps and `overflow`
// pulses for the cycle in which the wrapped zero is visible.
module stopwatch #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             tick,
    input  logic             lap_req,
    output logic [WIDTH-1:0] elapsed,
    output logic [WIDTH-1:0] lap,
    output logic             lap_valid,
    output logic             running,
    output logic             overflow
);

    localparam int            PW       = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_pre;
    logic [WIDTH-1:0] r_elapsed;
    logic [WIDTH-1:0] r_lap;
    logic             r_lap_valid;
    logic             r_running;
    logic             r_overflow;

    logic             w_count;
    logic             w_bump;
    logic             w_at_max;
    logic             w_capture;

    // A tick only counts while already in RUN; a same-cycle stop or clear wins.
    assign w_count   = (r_state == ST_RUN) && tick && !stop && !clear;
    assign w_bump    = w_count && (r_pre == PRE_LAST);
    assign w_at_max  = &r_elapsed;
    // Capture sees the registered count, i.e. the pre-increment value.
    assign w_capture = lap_req && !clear && (r_state != ST_IDLE);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state: clear beats stop beats start; stop outside RUN holds state.
    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = ST_IDLE;
        end else if (stop) begin
            if (r_state == ST_RUN) w_next = ST_PAUSE;
        end else if (start) begin
            w_next = ST_RUN;
        end
    end

    // Prescaler, elapsed count and overflow flag.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_pre      <= '0;
            r_elapsed  <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_pre      <= '0;
            r_elapsed  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_count) r_pre <= w_bump ? '0 : r_pre + 1'b1;
`ifdef STOPWATCH_SATURATE_EN
            if (w_bump) begin
                if (w_at_max) r_overflow <= 1'b1;
                else          r_elapsed  <= r_elapsed + 1'b1;
            end
`else
            r_overflow <= w_bump && w_at_max;
            if (w_bump) r_elapsed <= r_elapsed + 1'b1;
`endif
        end
    end

    // Lap register and its one-cycle valid pulse.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_lap       <= '0;
            r_lap_valid <= 1'b0;
        end else begin
            r_lap_valid <= w_capture;
            if (w_capture) r_lap <= r_elapsed;
        end
    end

    // Registered running flag, changing on the same edge as the state.
    always_ff @(posedge Clk) begin
        if (!Reset) r_running <= 1'b0;
        else        r_running <= (w_next == ST_RUN);
    end

    assign elapsed   = r_elapsed;
    assign lap       = r_lap;
    assign lap_valid = r_lap_valid;
    assign running   = r_running;
    assign overflow  = r_overflow;

endmodule

// File: doc/stopwatch.md
# stopwatch

Up-counting elapsed-time block, the complement of the countdown timer. The countdown loads a seed and decrements to `done`; the stopwatch starts at zero and accumulates qualified ticks until it is stopped. It sits beside the game-state logic. It measures frames or seconds survived and feeds the score/HUD path through a lap-capture register with a one-cycle valid pulse.

## Interface
- `WIDTH`, 8: width of `elapsed` and `lap`.
- `PRESCALE`, 1: number of qualified `tick` pulses per count increment (≥1).
- `Clk` in 1: system clock; all logic on the rising edge.
- `Reset` in 1: synchronous, active-low reset; sampled only on the rising edge of `Clk`.
- `start` in 1: enter or resume counting.
- `stop` in 1: pause counting and hold the value.
- `clear` in 1: zero the count and return to idle.
- `tick` in 1: time-base strobe (e.g. vsync edge); counts only while running.
- `lap_req` in 1: capture the current elapsed value.
- `elapsed` out WIDTH: current count.
- `lap` out WIDTH: last captured value.
- `lap_valid` out 1: one-cycle pulse when `lap` has just updated.
- `running` out 1: high in RUN.
- `overflow` out 1: count passed its maximum value (see Configuration).

## Operation
- States:
  - IDLE: `elapsed` = 0, not counting.
  - RUN: counting.
  - PAUSE: holding, not counting.
- Control priority per cycle: `clear` > `stop` > `start`.
- Transitions:
  - IDLE --start--> RUN.
  - RUN --stop--> PAUSE.
  - PAUSE --start--> RUN; `elapsed` is retained.
  - Any state --clear--> IDLE; zeroes `elapsed`, the prescaler and `overflow`.
  - `stop` in IDLE is ignored.
  - `start` in RUN is ignored.
- Prescaler: internal counter of `$clog2(PRESCALE+1)` bits.
  - Increments on `tick` in RUN.
  - On reaching PRESCALE−1 with `tick`, it wraps to 0 and `elapsed` increments by 1.
  - It holds its value in PAUSE and is not reset by `start`.
- Arithmetic: `elapsed` is unsigned WIDTH-bit. Behaviour at 2^WIDTH−1 is defined in Configuration.
- Lap capture:
  - `lap_req` in RUN or PAUSE loads `lap` with the registered `elapsed`. This is the pre-increment value when `tick` arrives in the same cycle.
  - `lap_req` in IDLE is ignored; `lap` holds and there is no pulse.
- `clear` together with `lap_req`: clear wins and no capture occurs.
- `stop` together with a qualifying `tick`: no increment; stop has taken effect.
- `start` from IDLE together with `tick`: no increment; counting begins on the next cycle.
- Reset mid-operation: everything returns to reset values on the next edge, regardless of the other inputs.

## Timing
- Reset values: state IDLE, `elapsed` = 0, `lap` = 0, `lap_valid` = 0, `running` = 0, `overflow` = 0, prescaler = 0.
- All outputs are registered; no combinational input-to-output paths.
- A `tick` sampled at edge N in RUN with the prescaler at terminal count gives the new `elapsed` visible after edge N.
- `running` rises or falls in the same edge as the state change.
- `lap_valid` is asserted for exactly the one cycle after the capturing edge. Back-to-back `lap_req` gives back-to-back pulses.
- `tick` is level-sampled. The driver supplies one-cycle pulses; a held `tick` counts every cycle.

## Configuration
- `STOPWATCH_SATURATE_EN` defined:
  - At `elapsed` = 2^WIDTH−1, further increments are blocked and `elapsed` holds at all-ones.
  - `overflow` sets on the first blocked increment and stays high (sticky) until `clear` or reset.
- Not defined:
  - `elapsed` wraps from 2^WIDTH−1 to 0.
  - `overflow` pulses high for exactly the one cycle in which the wrapped value 0 is visible.

## Test plan
- Reset held low 3 cycles with start/tick active -> all outputs 0, state IDLE; release, `start`, 5 ticks (PRESCALE=1) -> `elapsed`=5, `running`=1.
- PRESCALE=4, RUN, 10 ticks -> `elapsed`=2, prescaler=2; `stop`, 3 ticks -> `elapsed` stays 2; `start`, 2 ticks -> `elapsed`=3.
- `elapsed`=7, `lap_req` and `tick` in the same cycle -> `lap`=7, `elapsed`=8, `lap_valid` high for 1 cycle; `lap_req` in IDLE -> no pulse, `lap` unchanged.
- `clear`+`stop`+`lap_req`+`tick` together at `elapsed`=20 -> IDLE, `elapsed`=0, `lap` unchanged, no `lap_valid`.
- WIDTH=8, run past 255:
  - Macro defined -> `elapsed`=255 held, `overflow` stays high until `clear`.
  - Macro undefined -> `elapsed`=0 after 256 ticks, `overflow` is a 1-cycle pulse.
- Reset low asserted mid-RUN at `elapsed`=100 -> next edge `elapsed`=0, `running`=0, `lap`=0; `start` then required before counting resumes.
